// File: rtl/cpu4_pkg.sv
// Shared encodings for the 4-bit CPU: opcodes, control-unit states and ALU operations.
package cpu4_pkg;

  localparam int OPC_W_DEF  = 4;
  localparam int ADDR_W_DEF = 4;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_JZ  = 4'h5;
  localparam logic [3:0] OP_JNZ = 4'h6;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'b00,
    ST_FETCH  = 2'b01,
    ST_EXEC   = 2'b10,
    ST_HALTED = 2'b11
  } state_t;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;

endpackage

// File: rtl/cpu4_control_unit_if.sv
// Program-counter control bundle; the control unit is master, the counter is slave.
// Handshake: no valid/ready; the counter samples these every rising edge with
// priority halt > jump_en > ir_load_en(+1) > hold, and jump_en/ir_load_en are never both high.
interface cpu4_control_unit_if
  import cpu4_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
);
  logic              ir_load_en;
  logic              jump_en;
  logic [ADDR_W-1:0] jump_addr;
  logic              halt;

  modport master (output ir_load_en, output jump_en, output jump_addr, output halt);
  modport slave  (input ir_load_en, input jump_en, input jump_addr, input halt);
endinterface

// File: rtl/cpu4_instr_decoder.sv
// Pure combinational opcode decode; the caller qualifies every output with the EXEC state.
module cpu4_instr_decoder
  import cpu4_pkg::*;
#(
  parameter int OPC_W = OPC_W_DEF
) (
  input  logic [OPC_W-1:0] opcode,
  input  logic             zero_flag,
  output logic             acc_load_en,
  output logic [1:0]       alu_op,
  output logic             jump_req,
  output logic             halt_req,
  output logic             illegal
);

  always_comb begin
    acc_load_en = 1'b0;
    alu_op      = ALU_PASS;
    jump_req    = 1'b0;
    halt_req    = 1'b0;
    illegal     = 1'b0;
    case (opcode)
      OPC_W'(OP_NOP): ;
      OPC_W'(OP_LDI): begin acc_load_en = 1'b1; alu_op = ALU_PASS; end
      OPC_W'(OP_ADD): begin acc_load_en = 1'b1; alu_op = ALU_ADD;  end
      OPC_W'(OP_SUB): begin acc_load_en = 1'b1; alu_op = ALU_SUB;  end
      OPC_W'(OP_JMP): jump_req = 1'b1;
      OPC_W'(OP_JZ):  jump_req = zero_flag;
      OPC_W'(OP_JNZ): jump_req = ~zero_flag;
      OPC_W'(OP_HLT): halt_req = 1'b1;
      default:        illegal  = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu4_control_unit.sv
// Fetch/decode/execute sequencer: owns the IR and FSM and tells the PC when to step, jump or freeze.
module cpu4_control_unit
  import cpu4_pkg::*;
#(
  parameter int OPC_W  = OPC_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [OPC_W+ADDR_W-1:0] instr_in,
  input  logic                    zero_flag,
  input  logic                    resume,
  cpu4_control_unit_if.master     pc,
  output logic                    acc_load_en,
  output logic [1:0]              alu_op,
  output logic [ADDR_W-1:0]       imm,
  output logic                    illegal_op,
  output logic [1:0]              state_out
);

  state_t                  state;
  logic [OPC_W+ADDR_W-1:0] ir;

  logic       dec_acc_load_en;
  logic [1:0] dec_alu_op;
  logic       dec_jump_req;
  logic       dec_halt_req;
  logic       dec_illegal;
  logic       in_exec;

  cpu4_instr_decoder #(.OPC_W(OPC_W)) u_decoder (
    .opcode      (ir[OPC_W+ADDR_W-1:ADDR_W]),
    .zero_flag   (zero_flag),
    .acc_load_en (dec_acc_load_en),
    .alu_op      (dec_alu_op),
    .jump_req    (dec_jump_req),
    .halt_req    (dec_halt_req),
    .illegal     (dec_illegal)
  );

  // resume is only looked at in HALTED, which guarantees at least one halted cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_BOOT;
      ir    <= '0;
    end else begin
      case (state)
        ST_BOOT:   state <= ST_FETCH;
        ST_FETCH: begin
          ir    <= instr_in;
          state <= ST_EXEC;
        end
        ST_EXEC:   state <= dec_halt_req ? ST_HALTED : ST_FETCH;
        ST_HALTED: if (resume) state <= ST_FETCH;
        default:   state <= ST_BOOT;
      endcase
    end
  end

  // Strobes come from state/IR only; JZ/JNZ additionally see the live zero_flag.
  assign in_exec        = (state == ST_EXEC);
  assign pc.ir_load_en  = (state == ST_FETCH);
  assign pc.jump_en     = in_exec & dec_jump_req;
  assign pc.halt        = (in_exec & dec_halt_req) | (state == ST_HALTED);
  assign pc.jump_addr   = ir[ADDR_W-1:0];
  assign acc_load_en    = in_exec & dec_acc_load_en;
  assign alu_op         = in_exec ? dec_alu_op : ALU_PASS;
  assign imm            = ir[ADDR_W-1:0];
  assign illegal_op     = in_exec & dec_illegal;
  assign state_out      = state;

endmodule
